// File: rtl/stack_reverse_ctrl_if.sv
// Stream and stack-port bundle for stack_reverse_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface stack_reverse_ctrl_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              stk_PushPop;
  logic              stk_En;
  logic [DATA_W-1:0] stk_data_w;
  logic [DATA_W-1:0] stk_data_r;
  logic              stk_empty;
  logic              stk_full;

  modport slave (
    input  in_data, in_valid, in_last, out_ready, stk_data_r, stk_empty, stk_full,
    output in_ready, out_data, out_valid, out_last, stk_PushPop, stk_En, stk_data_w
  );

  modport master (
    output in_data, in_valid, in_last, out_ready, stk_data_r, stk_empty, stk_full,
    input  in_ready, out_data, out_valid, out_last, stk_PushPop, stk_En, stk_data_w
  );
endinterface

// File: rtl/stack_reverse_ctrl.sv
// Packet reverser: pushes an input packet into PushDownStack, then drains it LIFO.
// Optional STACK_REVERSE_SPLIT_FLAG_EN adds sticky split_o for drains forced by a full stack.
module stack_reverse_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 11
) (
  input  logic                 Clk,
  input  logic                 Rst,
  stack_reverse_ctrl_if.slave  bus
`ifdef STACK_REVERSE_SPLIT_FLAG_EN
  ,
  output logic                 split_o
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {FILL, POP, CAPT, OUT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             in_rdy;
  logic             accept;
  logic             full_hit;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= FILL;
    else      state <= state_nxt;
  end

  // in_ready is gated by Rst so it reads 0 while reset is held
  always_comb begin
    state_nxt       = state;
    in_rdy          = 1'b0;
    accept          = 1'b0;
    full_hit        = 1'b0;
    bus.stk_En      = 1'b0;
    bus.stk_PushPop = 1'b0;
    bus.stk_data_w  = '0;
    case (state)
      FILL: begin
        in_rdy   = Rst && !bus.stk_full && (count < DEPTH_C);
        accept   = bus.in_valid && in_rdy;
        full_hit = (count == DEPTH_M1);
        if (accept) begin
          bus.stk_En     = 1'b1;
          bus.stk_data_w = bus.in_data;
          if (bus.in_last || full_hit) state_nxt = POP;
        end
      end
      POP: begin
        bus.stk_En      = 1'b1;
        bus.stk_PushPop = 1'b1;
        state_nxt       = CAPT;
      end
      CAPT: state_nxt = OUT;
      OUT: begin
        if (bus.out_ready) state_nxt = (count == '0) ? FILL : POP;
      end
      default: state_nxt = FILL;
    endcase
    bus.in_ready = in_rdy;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count         <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) count <= count + CNT_W'(1);
        end
        POP: begin
          // An empty stack with entries still counted means the two disagree; end the drain here
          if (bus.stk_empty) count <= '0;
          else               count <= count - CNT_W'(1);
        end
        CAPT: begin
          bus.out_data  <= DATA_W'(bus.stk_data_r);
          bus.out_valid <= 1'b1;
          bus.out_last  <= (count == '0);
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_REVERSE_SPLIT_FLAG_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                   split_o <= 1'b0;
    else if (accept && full_hit && !bus.in_last) split_o <= 1'b1;
  end
`endif

endmodule

// File: doc/stack_reverse_ctrl.md
Name: stack_reverse_ctrl

Overview:
- Stream-side controller wrapped around PushDownStack; feeds its push port and consumes its pop output.
- Accepts a byte packet on a valid/ready input stream and pushes every byte into the stack.
- On the packet's last byte, or when the stack fills, drains the stack to a valid/ready output stream, so bytes leave in reversed (LIFO) order.
- Sits between the upstream byte source and any downstream consumer.

Parameters:
- DATA_W, 8: byte width; matches stack data_i/data_o.
- DEPTH, 1024: stack capacity in entries.
- CNT_W, 11: occupancy counter width; must hold 0..DEPTH.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  upstream byte.
- in_valid  in  1  upstream byte valid.
- in_last  in  1  marks last byte of packet.
- in_ready  out  1  controller accepts in_data this cycle.
- out_data  out  DATA_W  reversed byte.
- out_valid  out  1  out_data valid.
- out_last  out  1  marks final byte of a drain.
- out_ready  in  1  downstream accepts.
- stk_PushPop  out  1  to stack PushPop; 0=push, 1=pop.
- stk_En  out  1  to stack En; one-cycle operation strobe.
- stk_data_w  out  DATA_W  to stack data_i.
- stk_data_r  in  DATA_W  from stack data_o.
- stk_empty  in  1  from stack empty.
- stk_full  in  1  from stack full.

Behaviour:
- Stack contract:
  - Operation occurs at a rising Clk edge with stk_En=1.
  - Popped byte is valid on stk_data_r the cycle after the pop strobe.
- Reset (Rst=0, async): state=FILL, count=0, in_ready=0 during reset, out_valid=0, out_last=0, out_data=0, stk_En=0, stk_PushPop=0, stk_data_w=0.
- FILL:
  - in_ready = !stk_full && count<DEPTH.
  - Accept (in_valid & in_ready): stk_En=1, stk_PushPop=0, stk_data_w=in_data (combinational, same cycle); count+1.
  - Go to POP if in_last was accepted, or the accept makes count==DEPTH (forced split).
- POP: in_ready=0; stk_En=1, stk_PushPop=1 for exactly one cycle; count-1; go to CAPT.
- CAPT: register stk_data_r into out_data; out_valid=1; out_last=(count==0); go to OUT.
- OUT:
  - Hold out_data/out_valid/out_last stable until out_ready.
  - On handshake: out_valid=0; if count==0 go to FILL, else go to POP.
- Throughput: 1 byte/cycle in; 1 byte per 3 cycles out when out_ready is held high.
- Latency: first output byte asserts out_valid 2 cycles after the edge accepting in_last.
- Boundaries:
  - Single-byte packet: one push, one pop, out_last=1.
  - stk_empty=1 in POP while count!=0 is a consistency error: still strobe the pop, then force count=0 and out_last=1.
  - in_valid is ignored outside FILL.
  - out_ready held low stalls indefinitely with no stack activity.
  - Reset mid-drain: remaining stack contents are abandoned; the stack receives its own reset.
- stk_En is never 1 in two consecutive cycles of a pop sequence; push and pop are never strobed together.

Optional Feature:
- Macro: STACK_REVERSE_SPLIT_FLAG_EN.
- Defined:
  - Adds output split_o (1 bit).
  - split_o is sticky: set when a drain is forced by count==DEPTH without in_last; cleared only by reset.
  - out_last on a forced drain is still 1.
- Undefined:
  - No split_o port.
  - Forced-split drains are identical but unflagged.

Test Plan:
- Reset then push 1,2,3 with in_last on 3, out_ready=1 -> out sequence 3,2,1; out_last only on 1; in_ready=0 from in_last accept until after byte 1 handshake.
- Single byte 0xA5 with in_last -> exactly one output 0xA5, out_last=1, exactly one push strobe and one pop strobe.
- Stream bytes i=1..1023 (mod 256), no in_last, DEPTH=1024, then a 1024th byte -> forced drain after byte 1024; first output is byte 1024's value, last output is 0x01 with out_last=1; split_o=1 when macro defined.
- Packet 10,20,30 (last), out_ready toggled 0/1 every 2 cycles -> out_data stable while out_valid & !out_ready; order 30,20,10.
- Assert Rst low during OUT of a 4-byte drain -> all outputs return to reset values asynchronously; after release, a new packet 7,8 (last) yields 8,7.
- in_valid=1 continuously during a drain -> no pushes until state returns to FILL; next packet bytes are not lost or duplicated.
